// File: rtl/button_debouncer_pkg.sv
// Shared types and constants for the push-button debouncer and its
// synchronizer. Imported by button_debouncer.
`timescale 1ns/1ps

package button_debouncer_pkg;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    ARM_LOW  = 2'd1,
    HELD     = 2'd2,
    ARM_HIGH = 2'd3
  } deb_state_t;

  // Level of an active-low KEY pin when nobody touches it.
  localparam logic BTN_IDLE_LVL = 1'b1;

endpackage

// File: rtl/sync_2ff.sv
// Two-flop metastability synchronizer for one asynchronous board input.
// RESET_VAL lets each KEY/SW instance start at its own idle level.
`timescale 1ns/1ps

module sync_2ff #(
  parameter logic RESET_VAL = 1'b0
) (
  input  logic clk,
  input  logic reset_n,
  input  logic d,
  output logic q
);

  logic meta;

  // Two-stage capture of the asynchronous pin into the clk domain.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      meta <= RESET_VAL;
      q    <= RESET_VAL;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/button_debouncer.sv
// Debounces one active-low push-button for the PIO in_port and produces
// registered press/release strobes. Optional long-press strobe is built
// only when BUTTON_DEBOUNCER_LONG_PRESS_EN is defined.
//
// state    | meaning
// ---------+-----------------------------------------------------------
// IDLE     | released, btn_n_clean=1, waiting for s=0
// ARM_LOW  | s=0 seen, counting qualification cycles towards a press
// HELD     | pressed, btn_n_clean=0, waiting for s=1
// ARM_HIGH | s=1 seen, counting qualification cycles towards a release
`timescale 1ns/1ps

module button_debouncer
  import button_debouncer_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 1_000_000,
  parameter int LONG_CYCLES     = 50_000_000
) (
  input  logic clk,
  input  logic reset_n,
  input  logic btn_n_raw,
  output logic btn_n_clean,
  output logic press_pulse,
  output logic release_pulse,
  output logic long_press
);

  localparam int                 CNT_W    = $clog2(DEBOUNCE_CYCLES);
  localparam logic [CNT_W-1:0]   CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  deb_state_t       state;
  logic [CNT_W-1:0] cnt;
  logic             s;
  logic             press_accept;
  logic             release_accept;

  sync_2ff #(
    .RESET_VAL (BTN_IDLE_LVL)
  ) u_sync (
    .clk     (clk),
    .reset_n (reset_n),
    .d       (btn_n_raw),
    .q       (s)
  );

  // Qualification complete on this edge; shared by the FSM and hold counter.
  assign press_accept   = (state == ARM_LOW)  && !s && (cnt == CNT_LAST);
  assign release_accept = (state == ARM_HIGH) &&  s && (cnt == CNT_LAST);

  // Debounce FSM: the counter is cleared on every state change, so any
  // glitch during ARM_* restarts qualification from zero.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state         <= IDLE;
      cnt           <= '0;
      btn_n_clean   <= BTN_IDLE_LVL;
      press_pulse   <= 1'b0;
      release_pulse <= 1'b0;
    end else begin
      press_pulse   <= 1'b0;
      release_pulse <= 1'b0;
      case (state)
        IDLE: begin
          if (!s) begin
            state <= ARM_LOW;
            cnt   <= '0;
          end
        end
        ARM_LOW: begin
          if (s) begin
            state <= IDLE;
            cnt   <= '0;
          end else if (press_accept) begin
            state       <= HELD;
            cnt         <= '0;
            btn_n_clean <= 1'b0;
            press_pulse <= 1'b1;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        HELD: begin
          if (s) begin
            state <= ARM_HIGH;
            cnt   <= '0;
          end
        end
        ARM_HIGH: begin
          if (!s) begin
            state <= HELD;
            cnt   <= '0;
          end else if (release_accept) begin
            state         <= IDLE;
            cnt           <= '0;
            btn_n_clean   <= BTN_IDLE_LVL;
            release_pulse <= 1'b1;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        default: begin
          state <= IDLE;
          cnt   <= '0;
        end
      endcase
    end
  end

`ifdef BUTTON_DEBOUNCER_LONG_PRESS_EN
  localparam int                  HOLD_W    = $clog2(LONG_CYCLES + 1);
  localparam logic [HOLD_W-1:0]   HOLD_LAST = HOLD_W'(LONG_CYCLES);

  logic [HOLD_W-1:0] hold_cnt;
  logic [HOLD_W-1:0] hold_nxt;

  assign hold_nxt = hold_cnt + 1'b1;

  // Hold timer: restarts on a fresh press, survives a bounce back from
  // ARM_HIGH, saturates at LONG_CYCLES so the strobe fires once per press.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      hold_cnt   <= '0;
      long_press <= 1'b0;
    end else begin
      long_press <= 1'b0;
      if (press_accept || release_accept) begin
        hold_cnt <= '0;
      end else if ((state == HELD || state == ARM_HIGH) && (hold_cnt != HOLD_LAST)) begin
        hold_cnt <= hold_nxt;
        if (hold_nxt == HOLD_LAST) begin
          long_press <= 1'b1;
        end
      end
    end
  end
`else
  logic long_cycles_unused;

  assign long_cycles_unused = (LONG_CYCLES > 0);
  assign long_press         = 1'b0;
`endif

endmodule

// File: tb/tb_button_debouncer.sv
// Directed self-checking bench for button_debouncer with DEBOUNCE_CYCLES=8
// and LONG_CYCLES=32. Edge numbering: "edge 0" is the first rising edge that
// samples a newly driven pin value.
`timescale 1ns/1ps

module tb_button_debouncer;

  logic clk = 1'b0;
  logic reset_n;
  logic btn_n_raw;
  logic btn_n_clean;
  logic press_pulse;
  logic release_pulse;
  logic long_press;

  int n_total = 0;
  int n_pass  = 0;

  int   edge_i;
  int   press_cnt, rel_cnt, long_cnt, both_cnt;
  int   press_at, rel_at, long_at, clean_chg_at;
  logic clean_prev;
  int   exp_long;

  always #5 clk = ~clk;

  button_debouncer #(
    .DEBOUNCE_CYCLES (8),
    .LONG_CYCLES     (32)
  ) dut (
    .clk           (clk),
    .reset_n       (reset_n),
    .btn_n_raw     (btn_n_raw),
    .btn_n_clean   (btn_n_clean),
    .press_pulse   (press_pulse),
    .release_pulse (release_pulse),
    .long_press    (long_press)
  );

  task automatic chk(input string tag, input int obs, input int exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %0d, expected %0d", tag, obs, exp);
  endtask

  task automatic clear_mon();
    edge_i       = -1;
    press_cnt    = 0;
    rel_cnt      = 0;
    long_cnt     = 0;
    both_cnt     = 0;
    press_at     = -1;
    rel_at       = -1;
    long_at      = -1;
    clean_chg_at = -1;
    clean_prev   = btn_n_clean;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    edge_i++;
    if (press_pulse) begin
      press_cnt++;
      if (press_at < 0) press_at = edge_i;
    end
    if (release_pulse) begin
      rel_cnt++;
      if (rel_at < 0) rel_at = edge_i;
    end
    if (long_press) begin
      long_cnt++;
      if (long_at < 0) long_at = edge_i;
    end
    if (press_pulse && release_pulse) both_cnt++;
    if (btn_n_clean !== clean_prev && clean_chg_at < 0) clean_chg_at = edge_i;
    clean_prev = btn_n_clean;
  endtask

  initial begin
`ifdef BUTTON_DEBOUNCER_LONG_PRESS_EN
    exp_long = 1;
`else
    exp_long = 0;
`endif

    // Reset held with the button pressed.
    reset_n   = 1'b0;
    btn_n_raw = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_clean", btn_n_clean, 1);
    chk("rst_press", press_pulse, 0);
    chk("rst_release", release_pulse, 0);
    chk("rst_long", long_press, 0);

    // Release reset with the button still held: seen as a new press.
    reset_n = 1'b1;
    clear_mon();
    repeat (12) tick();
    chk("rstrel_press_at", press_at, 10);
    chk("rstrel_press_cnt", press_cnt, 1);
    chk("rstrel_clean_at", clean_chg_at, 10);

    btn_n_raw = 1'b1;
    clear_mon();
    repeat (14) tick();
    chk("rstrel_release_at", rel_at, 10);
    chk("rstrel_release_cnt", rel_cnt, 1);
    chk("rstrel_clean_hi", btn_n_clean, 1);

    // Clean press and release.
    btn_n_raw = 1'b0;
    clear_mon();
    repeat (12) tick();
    chk("clean_press_at", press_at, 10);
    chk("clean_press_cnt", press_cnt, 1);
    chk("clean_fall_at", clean_chg_at, 10);
    chk("clean_no_release", rel_cnt, 0);

    btn_n_raw = 1'b1;
    clear_mon();
    repeat (14) tick();
    chk("clean_release_at", rel_at, 10);
    chk("clean_rise_at", clean_chg_at, 10);
    chk("clean_no_press", press_cnt, 0);

    // Bounce: toggle every 3 cycles for 40 cycles, then settle low.
    clear_mon();
    for (int i = 0; i < 40; i++) begin
      btn_n_raw = ((i / 3) % 2 == 0) ? 1'b0 : 1'b1;
      tick();
    end
    chk("bounce_no_press", press_cnt, 0);
    chk("bounce_no_release", rel_cnt, 0);
    chk("bounce_clean_stable", clean_chg_at, -1);

    btn_n_raw = 1'b0;
    clear_mon();
    repeat (14) tick();
    chk("bounce_settle_press_at", press_at, 10);
    chk("bounce_settle_press_cnt", press_cnt, 1);

    btn_n_raw = 1'b1;
    clear_mon();
    repeat (14) tick();
    chk("bounce_release_at", rel_at, 10);

    // 8-cycle low pulse: rejected.
    btn_n_raw = 1'b0;
    clear_mon();
    repeat (8) tick();
    btn_n_raw = 1'b1;
    repeat (14) tick();
    chk("w8_no_press", press_cnt, 0);
    chk("w8_no_release", rel_cnt, 0);
    chk("w8_clean_stable", clean_chg_at, -1);

    // 9-cycle low pulse: accepted, release 10 cycles after the pin returns.
    btn_n_raw = 1'b0;
    clear_mon();
    repeat (9) tick();
    btn_n_raw = 1'b1;
    repeat (14) tick();
    chk("w9_press_at", press_at, 10);
    chk("w9_press_cnt", press_cnt, 1);
    chk("w9_release_at", rel_at, 19);
    chk("w9_release_cnt", rel_cnt, 1);

    // Long hold with a 2-cycle release glitch at hold cycle 20.
    btn_n_raw = 1'b0;
    clear_mon();
    repeat (30) tick();
    btn_n_raw = 1'b1;
    repeat (2) tick();
    btn_n_raw = 1'b0;
    repeat (40) tick();
    chk("long_press_at", press_at, 10);
    chk("long_press_cnt", press_cnt, 1);
    chk("long_no_release", rel_cnt, 0);
    chk("long_clean_low", btn_n_clean, 0);
    chk("long_cnt", long_cnt, exp_long);
`ifdef BUTTON_DEBOUNCER_LONG_PRESS_EN
    chk("long_at", long_at, 42);
`endif

    btn_n_raw = 1'b1;
    clear_mon();
    repeat (14) tick();
    chk("long_release_at", rel_at, 10);
    chk("long_none_after", long_cnt, 0);

    // Reset asserted at hold cycle 5.
    btn_n_raw = 1'b0;
    clear_mon();
    repeat (15) tick();
    chk("midhold_press_at", press_at, 10);
    chk("midhold_clean_low", btn_n_clean, 0);
    reset_n = 1'b0;
    #1;
    chk("midhold_async_clean", btn_n_clean, 1);
    chk("midhold_async_press", press_pulse, 0);
    btn_n_raw = 1'b1;
    clear_mon();
    repeat (3) tick();
    reset_n = 1'b1;
    repeat (15) tick();
    chk("midhold_no_release", rel_cnt, 0);
    chk("midhold_no_press", press_cnt, 0);
    chk("midhold_clean_stable", clean_chg_at, -1);

    chk("never_both_strobes", both_cnt, 0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/button_debouncer.md
# button_debouncer

Debounces one raw mechanical push-button (active-low, board KEY style) and delivers a clean active-low level to the PIO input port, whose falling-edge capture then raises the Nios II interrupt. It sits directly upstream of the PIO `in_port`, between the board pin and the Qsys system. It also provides single-cycle press and release strobes and an optional long-press strobe for local fabric logic.

## Interface
- `DEBOUNCE_CYCLES`, default 1_000_000: cycles the synchronized input must differ stably from the output before the output follows. This is 20 ms at 50 MHz. Legal range is ≥ 2.
- `LONG_CYCLES`, default 50_000_000: cycles of debounced press before `long_press` fires. Legal range is ≥ 1. Used only with `LONG_PRESS_EN`.
- `clk` input 1: system clock, 50 MHz.
- `reset_n` input 1: reset, asynchronous, active-low.
- `btn_n_raw` input 1: raw button pin, asynchronous to `clk`. 0 = pressed.
- `btn_n_clean` output 1: debounced level, 0 = pressed. Drives PIO `in_port`.
- `press_pulse` output 1: one-cycle strobe on the debounced 1→0 transition.
- `release_pulse` output 1: one-cycle strobe on the debounced 0→1 transition.
- `long_press` output 1: one-cycle strobe when the button has been held `LONG_CYCLES` after the debounced press.

## Operation
- Two-flop synchronizer on `btn_n_raw`. Both flops reset to 1 (idle). Its output is called `s`.
- The FSM has four states:
  - `IDLE`: `btn_n_clean`=1. If `s`=0, clear the counter and go to `ARM_LOW`.
  - `ARM_LOW`: if `s`=1, go to `IDLE` (bounce; the counter is discarded). Otherwise increment the counter. When the counter reaches `DEBOUNCE_CYCLES-1` with `s` still 0, go to `HELD`, drive `btn_n_clean`←0 and set `press_pulse`←1.
  - `HELD`: `btn_n_clean`=0. If `s`=1, clear the counter and go to `ARM_HIGH`.
  - `ARM_HIGH`: if `s`=0, go to `HELD`. Otherwise increment the counter. At `DEBOUNCE_CYCLES-1` with `s` still 1, go to `IDLE`, drive `btn_n_clean`←1 and set `release_pulse`←1.
- The debounce counter is `$clog2(DEBOUNCE_CYCLES)` bits wide, unsigned, and never wraps; it is cleared on every state entry.
- Any single-cycle glitch in `s` during `ARM_*` restarts qualification from zero on the next arm.
- The pulse outputs are registered and are high for exactly one cycle per accepted transition. `press_pulse` and `release_pulse` are never high in the same cycle.
- Reset values: `btn_n_clean`=1, `press_pulse`=0, `release_pulse`=0, `long_press`=0, state=`IDLE`, counters=0.
- If reset is asserted mid-qualification or mid-hold, all outputs return to their reset values asynchronously. No pulse is emitted on reset assertion or on release.
- If the button is already held when reset is released, it is seen as a new press after full qualification.

## Timing
- Press latency: with `btn_n_raw` falling at edge 0 and then stable, `btn_n_clean` falls and `press_pulse` rises at edge `DEBOUNCE_CYCLES+2`. This is 2 synchronizer cycles plus `DEBOUNCE_CYCLES` qualification cycles. The first counted cycle is the `IDLE`→`ARM_LOW` edge.
- Release latency is identical and symmetric.
- Minimum accepted pulse width at the pin is `DEBOUNCE_CYCLES+1` cycles. Anything shorter is fully rejected, with no output change and no strobe.
- The PIO sees exactly one falling edge per qualified press, so its edge capture sets exactly once.

## Configuration
- Macro `BUTTON_DEBOUNCER_LONG_PRESS_EN`.
- Defined:
  - A hold counter of `$clog2(LONG_CYCLES+1)` bits runs while in `HELD` or `ARM_HIGH`. It clears on entry to `HELD` from `ARM_LOW` only; a bounce back from `ARM_HIGH` keeps the count.
  - `long_press` pulses one cycle when the count reaches `LONG_CYCLES`, which is `LONG_CYCLES` cycles after `press_pulse`. It fires at most once per press.
  - The hold counter saturates and does not wrap. It is cleared on entry to `IDLE`.
- Undefined: the hold counter is absent, `long_press` is tied to 0, and `LONG_CYCLES` is ignored.

## Structure
- Package `button_debouncer_pkg` holds:
  - the state enum `deb_state_t` (`IDLE`, `ARM_LOW`, `HELD`, `ARM_HIGH`);
  - the localparam reset level `BTN_IDLE_LVL` = 1'b1.
- Sub-module `sync_2ff` (1 bit, with a reset-value parameter) holds the metastability synchronizer and is reusable for the other KEY/SW inputs.
- The FSM, counters and strobes live in `button_debouncer`.

## Test plan
All scenarios use `DEBOUNCE_CYCLES`=8 and `LONG_CYCLES`=32.
- Reset check: hold `reset_n`=0 with `btn_n_raw`=0 → `btn_n_clean`=1 and all strobes are 0. Release reset with the button still held → `press_pulse` appears at cycle 10 after release.
- Clean press: drop `btn_n_raw` to 0 at edge 0 and hold it → `btn_n_clean`=0 and `press_pulse`=1 at edge 10 only. Raise it again → `release_pulse` comes 10 cycles later.
- Bounce rejection: toggle `btn_n_raw` 0/1 every 3 cycles for 40 cycles, then settle at 0 → no strobes during toggling. A single `press_pulse` comes 10 cycles after settling.
- Minimum width: a 0 pulse of 8 cycles → no change. A 0 pulse of 9 cycles → one `press_pulse`, then `release_pulse` 10 cycles after the pin returns high.
- Long press (macro defined): hold for 60 cycles after `press_pulse` → exactly one `long_press`, 32 cycles after `press_pulse`. A 2-cycle release glitch at hold cycle 20 does not re-arm or delay it. Macro undefined → `long_press` stays at 0.
- Reset mid-hold: assert `reset_n` at hold cycle 5 → `btn_n_clean`=1 immediately, and no `release_pulse` is emitted.
